sprite_compositor: RTL
======================

// Module: sprite_compositor
// PURPOSE
//  N-sprite overlay engine between the background generator and the VGA output stage.
//  Holds per-sprite position, attribute and 1-bit mask registers, written over a shared 32-bit bus.
//  Composites the highest-priority opaque sprite pixel over the incoming background RGB.
//  Latches a sticky sprite-collision flag per frame.
//  Generalises the single-sprite overlay with these additions:
//   - N sprites with fixed priority
//   - writable masks
//   - frame-synchronous shadow registers
//   - collision detect
// PARAMETERS
//  NUM_SPRITES  4   sprite slots, 1..16; slot 0 = highest priority
//  SPR_W        16  sprite width in pixels, 1..16
//  SPR_H        16  sprite height in lines, 1..16
//  COLOR_W      8   bits per colour channel
// PORTS
//  clk        in   1                   pixel clock
//  rst        in   1                   asynchronous, active-low reset
//  pixel_x    in   10                  current column
//  pixel_y    in   10                  current line
//  bg_r       in   COLOR_W             background red
//  bg_g       in   COLOR_W             background green
//  bg_b       in   COLOR_W             background blue
//  frame_start in  1                   one-cycle pulse at start of vertical blank
//  data_in    in   32                  register write data
//  sel        in   4                   target sprite index
//  load_pos   in   1                   write position
//  load_att   in   1                   write attributes
//  load_row   in   1                   write one mask row
//  pixel_r    out  COLOR_W             composited red
//  pixel_g    out  COLOR_W             composited green
//  pixel_b    out  COLOR_W             composited blue
//  hit_valid  out  1                   an opaque sprite pixel is shown this cycle
//  hit_id     out  4                   index of the shown sprite; 0 when hit_valid=0
//  collision  out  1                   sticky: two or more opaque sprite pixels coincided this frame
// BEHAVIOUR
//  Reset (rst=0, async):
//   - all pos/att/mask registers (shadow and active) = 0, so all sprites disabled
//   - all outputs = 0; pipeline registers = 0
//  Writes (same cycle, sel < NUM_SPRITES; sel >= NUM_SPRITES is ignored):
//   - load_pos: shadow x = data_in[9:0], shadow y = data_in[25:16]
//   - load_att: shadow colour = data_in[23:0] {R[23:16],G[15:8],B[7:0]}; for COLOR_W<8 take each field's MSBs
//   - load_att: shadow enable = data_in[24]
//   - load_row: mask[data_in[31:28]] = data_in[SPR_W-1:0], written straight to the active mask
//   - load_row with row index >= SPR_H is ignored
//   - several load_* strobes in one cycle: pos > att > row; the losers are dropped
//  Shadow commit:
//   - on frame_start every active pos/att register takes its shadow value
//   - a write coinciding with frame_start lands in both shadow and active
//  Hit test, per sprite, stage 1:
//   - 11-bit compares: x0 <= pixel_x < x0+SPR_W and y0 <= pixel_y < y0+SPR_H
//   - no wrap: a sprite extending past 1023 is clipped
//   - col = pixel_x-x0, row = pixel_y-y0
//   - opaque = enable & inside & mask[row][SPR_W-1-col]   (MSB = leftmost pixel)
//  Select, stage 2:
//   - lowest opaque index wins and drives its colour, hit_valid=1, hit_id=index
//   - no opaque sprite: bg passes through, hit_valid=0
//  Latency:
//   - exactly 2 clk from pixel_x/pixel_y/bg_* to pixel_*/hit_*
//   - bg is delayed 2 stages internally to stay aligned
//  collision:
//   - set when >= 2 opaque bits in stage 2
//   - cleared by frame_start, except that a collision detected in the same cycle keeps it set
//  Reset mid-frame: outputs return to 0 immediately; no partial state is retained.
// STRUCTURE
//  sprite_defs.vh holds:
//   - write-field bit positions (POS_X_LSB, POS_Y_LSB, ATT_EN_BIT, ROW_IDX_LSB)
//   - SEL_W = 4
//   - PIPE_LAT = 2
//  Sub-module sprite_slot, one per generate index, contains:
//   - shadow/active pos and att registers
//   - the mask array
//   - the stage-1 hit test
//   - outputs: opaque bit and colour
//  Top level contains:
//   - write decode
//   - priority encoder
//   - bg delay line
//   - output registers
//   - collision flag
// TESTING
//  1 Reset, then sweep a full frame.
//    -> pixel_* equals bg delayed 2 clk; hit_valid=0, collision=0 throughout.
//  2 Sprite 0: pos (100,50), colour 0xFF0000, en=1, mask rows all 1s; frame_start.
//    -> (100..115, 50..65) shows R=FF; (99,50) and (116,50) show bg.
//    -> output appears exactly 2 clk after the pixel coordinate.
//  3 Row 0 mask = 0x8001.
//    -> only columns 100 and 115 of line 50 are opaque; other columns of line 50 show bg.
//  4 Sprites 0 and 2 overlap at (200,200) with different colours.
//    -> sprite 0 colour shown, hit_id=0, collision=1.
//    -> collision stays 1 until the next frame_start and clears there if no overlap recurs.
//  5 Write pos (300,300) mid-frame.
//    -> sprite stays at its old position until frame_start.
//    -> a write pulsed together with frame_start takes effect immediately.
//  6 Edge cases:
//    - sprite at x=1020 -> only 1020..1023 are drawn, no wrap to column 0.
//    - sel=NUM_SPRITES write -> ignored.
//    - load_pos+load_att together -> only pos is updated.
//    - rst asserted mid-line -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/sprite_compositor_pkg.sv
// Shared field positions, widths and write-strobe decode for the sprite compositor.
// Pure definitions: no latency, no backpressure.
package sprite_compositor_pkg;

  localparam int COORD_W     = 10;
  localparam int SEL_W       = 4;
  localparam int PIPE_LAT    = 2;
  localparam int POS_X_LSB   = 0;
  localparam int POS_Y_LSB   = 16;
  localparam int ATT_EN_BIT  = 24;
  localparam int ROW_IDX_LSB = 28;
  localparam int ROW_IDX_W   = 4;

  typedef enum logic [1:0] {
    WR_NONE,
    WR_POS,
    WR_ATT,
    WR_ROW
  } wr_kind_e;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
  } pos_t;

  // Simultaneous strobes resolve pos > att > row; the losers are dropped.
  function automatic wr_kind_e decode_wr(input logic pos, input logic att, input logic row);
    wr_kind_e k;
    k = WR_NONE;
    if (row) k = WR_ROW;
    if (att) k = WR_ATT;
    if (pos) k = WR_POS;
    return k;
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel stream, register-write bus and composited output of the sprite compositor.
// Wiring only: no latency, no backpressure (the pixel stream never stalls).
interface sprite_compositor_if #(
  parameter int COLOR_W = 8
);
  import sprite_compositor_pkg::*;

  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic [COLOR_W-1:0] bg_r;
  logic [COLOR_W-1:0] bg_g;
  logic [COLOR_W-1:0] bg_b;
  logic               frame_start;
  logic [31:0]        data_in;
  logic [SEL_W-1:0]   sel;
  logic               load_pos;
  logic               load_att;
  logic               load_row;
  logic [COLOR_W-1:0] pixel_r;
  logic [COLOR_W-1:0] pixel_g;
  logic [COLOR_W-1:0] pixel_b;
  logic               hit_valid;
  logic [SEL_W-1:0]   hit_id;
  logic               collision;

  modport master (
    output pixel_x, pixel_y, bg_r, bg_g, bg_b, frame_start,
    output data_in, sel, load_pos, load_att, load_row,
    input  pixel_r, pixel_g, pixel_b, hit_valid, hit_id, collision
  );

  modport slave (
    input  pixel_x, pixel_y, bg_r, bg_g, bg_b, frame_start,
    input  data_in, sel, load_pos, load_att, load_row,
    output pixel_r, pixel_g, pixel_b, hit_valid, hit_id, collision
  );

endinterface

// File: rtl/sprite_compositor_slot.sv
// One sprite: shadow/active pos+att, writable 1-bit mask, registered stage-1 hit test.
// Latency 1 clk from pixel coordinate to o_opaque/o_color; no backpressure.
module sprite_compositor_slot
  import sprite_compositor_pkg::*;
#(
  parameter int SPR_W   = 16,
  parameter int SPR_H   = 16,
  parameter int COLOR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  wr_kind_e             i_wr,
  input  logic [31:0]          i_data,
  input  logic                 i_frame_start,
  input  logic [COORD_W-1:0]   i_pixel_x,
  input  logic [COORD_W-1:0]   i_pixel_y,
  output logic                 o_opaque,
  output logic [3*COLOR_W-1:0] o_color
);

  localparam int RGB_W = 3 * COLOR_W;

  pos_t                 r_pos_sh, r_pos_ac;
  logic                 r_en_sh, r_en_ac;
  logic [RGB_W-1:0]     r_col_sh, r_col_ac;
  logic [SPR_W-1:0]     r_mask [SPR_H];
  logic                 r_opaque;
  logic [RGB_W-1:0]     r_color;

  pos_t                 w_pos_new, w_pos_sh_nxt;
  logic                 w_en_sh_nxt;
  logic [RGB_W-1:0]     w_col_new, w_col_sh_nxt;
  logic [ROW_IDX_W-1:0] w_row_idx;
  logic [COORD_W:0]     w_px, w_py, w_x0, w_y0, w_dx, w_dy;
  logic                 w_in_x, w_in_y, w_bit;
  logic                 w_unused;

  assign w_pos_new = '{y: i_data[POS_Y_LSB +: COORD_W], x: i_data[POS_X_LSB +: COORD_W]};
  assign w_col_new = {i_data[23 -: COLOR_W], i_data[15 -: COLOR_W], i_data[7 -: COLOR_W]};
  assign w_row_idx = i_data[ROW_IDX_LSB +: ROW_IDX_W];

  // Shadow next-state is also what the active copy takes on frame_start,
  // so a write coinciding with frame_start lands in both.
  assign w_pos_sh_nxt = (i_wr == WR_POS) ? w_pos_new : r_pos_sh;
  assign w_en_sh_nxt  = (i_wr == WR_ATT) ? i_data[ATT_EN_BIT] : r_en_sh;
  assign w_col_sh_nxt = (i_wr == WR_ATT) ? w_col_new : r_col_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos_sh <= '0;
      r_pos_ac <= '0;
      r_en_sh  <= 1'b0;
      r_en_ac  <= 1'b0;
      r_col_sh <= '0;
      r_col_ac <= '0;
      for (int i = 0; i < SPR_H; i++) r_mask[i] <= '0;
    end else begin
      r_pos_sh <= w_pos_sh_nxt;
      r_en_sh  <= w_en_sh_nxt;
      r_col_sh <= w_col_sh_nxt;
      if (i_frame_start) begin
        r_pos_ac <= w_pos_sh_nxt;
        r_en_ac  <= w_en_sh_nxt;
        r_col_ac <= w_col_sh_nxt;
      end
      if (i_wr == WR_ROW && 32'(w_row_idx) < SPR_H)
        r_mask[w_row_idx] <= i_data[SPR_W-1:0];
    end
  end

  // 11-bit compares: pixel coordinates stop at 1023, so a sprite past the edge is clipped.
  assign w_px   = {1'b0, i_pixel_x};
  assign w_py   = {1'b0, i_pixel_y};
  assign w_x0   = {1'b0, r_pos_ac.x};
  assign w_y0   = {1'b0, r_pos_ac.y};
  assign w_dx   = w_px - w_x0;
  assign w_dy   = w_py - w_y0;
  assign w_in_x = (w_px >= w_x0) && (w_px < w_x0 + 11'(SPR_W));
  assign w_in_y = (w_py >= w_y0) && (w_py < w_y0 + 11'(SPR_H));

  always_comb begin
    w_bit = 1'b0;
    if (w_in_x && w_in_y)
      w_bit = r_mask[w_dy[3:0]][4'(SPR_W-1) - w_dx[3:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opaque <= 1'b0;
      r_color  <= '0;
    end else begin
      r_opaque <= r_en_ac & w_bit;
      r_color  <= r_col_ac;
    end
  end

  assign o_opaque = r_opaque;
  assign o_color  = r_color;
  assign w_unused = ^{i_data, w_dx, w_dy};

endmodule

// File: rtl/sprite_compositor.sv
// N-sprite overlay: write decode, fixed-priority select, bg alignment, sticky collision.
// Latency exactly 2 clk from pixel_x/y/bg_* to pixel_*/hit_*; no backpressure.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int NUM_SPRITES = 4,
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 16,
  parameter int COLOR_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  sprite_compositor_if.slave bus
);

  localparam int RGB_W = 3 * COLOR_W;

  wr_kind_e               w_kind;
  logic [NUM_SPRITES-1:0] w_opaque;
  logic [RGB_W-1:0]       w_color [NUM_SPRITES];
  logic                   w_hit;
  logic [SEL_W-1:0]       w_id;
  logic [RGB_W-1:0]       w_sel_color;
  logic                   w_multi;

  logic [RGB_W-1:0]       r_bg_d1;
  logic [RGB_W-1:0]       r_pix;
  logic                   r_hit;
  logic [SEL_W-1:0]       r_id;
  logic                   r_coll;

  assign w_kind = decode_wr(bus.load_pos, bus.load_att, bus.load_row);

  // A sel outside 0..NUM_SPRITES-1 matches no slot, so that write is dropped.
  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
    wr_kind_e w_slot_wr;
    assign w_slot_wr = (bus.sel == SEL_W'(gi)) ? w_kind : WR_NONE;

    sprite_compositor_slot #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .COLOR_W (COLOR_W)
    ) u_slot (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_wr          (w_slot_wr),
      .i_data        (bus.data_in),
      .i_frame_start (bus.frame_start),
      .i_pixel_x     (bus.pixel_x),
      .i_pixel_y     (bus.pixel_y),
      .o_opaque      (w_opaque[gi]),
      .o_color       (w_color[gi])
    );
  end

  always_comb begin
    w_hit       = 1'b0;
    w_id        = '0;
    w_sel_color = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_opaque[i]) begin
        w_hit       = 1'b1;
        w_id        = SEL_W'(i);
        w_sel_color = w_color[i];
      end
    end
  end

  assign w_multi = ($countones(w_opaque) > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bg_d1 <= '0;
      r_pix   <= '0;
      r_hit   <= 1'b0;
      r_id    <= '0;
      r_coll  <= 1'b0;
    end else begin
      r_bg_d1 <= {bus.bg_r, bus.bg_g, bus.bg_b};
      r_pix   <= w_hit ? w_sel_color : r_bg_d1;
      r_hit   <= w_hit;
      r_id    <= w_id;
      // frame_start clears, but a collision seen in that same cycle survives.
      r_coll  <= bus.frame_start ? w_multi : (r_coll | w_multi);
    end
  end

  assign bus.pixel_r   = r_pix[RGB_W-1 -: COLOR_W];
  assign bus.pixel_g   = r_pix[2*COLOR_W-1 -: COLOR_W];
  assign bus.pixel_b   = r_pix[COLOR_W-1:0];
  assign bus.hit_valid = r_hit;
  assign bus.hit_id    = r_id;
  assign bus.collision = r_coll;

endmodule
